// File: rtl/mm_frame_pkg.sv
// Shared definitions for the frame builder: magic bytes, field positions,
// write-side state encoding and word-building helpers.
package mm_frame_pkg;

    localparam logic [7:0] HEADER_MAGIC = 8'hAA;
    localparam logic [7:0] FOOTER_MAGIC = 8'h55;

    // Field positions inside the 128-bit header / footer words
    localparam int MAGIC_LSB     = 120;
    localparam int CHID_LSB      = 112;
    localparam int HDR_BL_LSB    = 100;
    localparam int HDR_TS_LSB    = 44;
    localparam int FTR_CNT_LSB   = 96;
    localparam int FTR_TRUNC_BIT = 95;

    // Free entries needed before a header (header + one beat + footer)
    // and before a data beat (beat + footer).
    localparam int HDR_ROOM = 3;
    localparam int DAT_ROOM = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BODY    = 2'd1,
        ST_FOOTER  = 2'd2,
        ST_DISCARD = 2'd3
    } wr_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [127:0] make_header(input logic [7:0]  ch,
                                                 input logic [11:0] bl,
                                                 input logic [43:0] ts);
        logic [127:0] w;
        w = '0;
        w[MAGIC_LSB +: 8]   = HEADER_MAGIC;
        w[CHID_LSB +: 8]    = ch;
        w[HDR_BL_LSB +: 12] = bl;
        w[HDR_TS_LSB +: 44] = ts;
        return w;
    endfunction

    function automatic logic [127:0] make_footer(input logic [7:0]  ch,
                                                 input logic [15:0] cnt,
                                                 input logic        trunc);
        logic [127:0] w;
        w = '0;
        w[MAGIC_LSB +: 8]    = FOOTER_MAGIC;
        w[CHID_LSB +: 8]     = ch;
        w[FTR_CNT_LSB +: 16] = cnt;
        w[FTR_TRUNC_BIT]     = trunc;
        return w;
    endfunction

endpackage

// File: rtl/mm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with free-space output.
// Head entry reads as zero while empty so the stream bus is quiet.
module mm_sync_fifo #(
    parameter int DEPTH = 256,
    parameter int W     = 129
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop, full;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push at full is accepted when the head leaves on the same edge.
    assign do_push = push_i && (!full || do_pop);
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    assign free_o  = CW'(DEPTH) - cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array; no reset needed since reads are gated by empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mm_frame_builder.sv
// Wraps triggered ADC words into header / body / footer frames and streams
// them out of an FWFT FIFO over AXI4-Stream. The word layout assumes the
// default 128-bit data, 44-bit time stamp and 12-bit baseline widths.
module mm_frame_builder
    import mm_frame_pkg::*;
#(
    parameter logic [7:0] CH_ID                = 8'd0,
    parameter int         FIFO_DEPTH           = 256,
    parameter int         TIME_STAMP_WIDTH     = 44,
    parameter int         ADC_RESOLUTION_WIDTH = 12,
    parameter int         TDATA_WIDTH          = 128
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESETN,
    input  logic                            TRIGGERED,
    input  logic [TDATA_WIDTH-1:0]          DATA,
    input  logic                            VALID,
    input  logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP,
    input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT,
    output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    output logic [15:0]                     DROP_COUNT,
    output logic [15:0]                     TRUNC_COUNT
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e              state_q;
    logic                   trig_q;
    logic [TDATA_WIDTH-1:0] dly_q;
    logic [15:0]            beats_q;
    logic                   trunc_q;
    logic [15:0]            drop_cnt_q, trunc_cnt_q;

    logic [FW-1:0]          free;
    logic                   fifo_empty;
    logic [TDATA_WIDTH:0]   fifo_dout;
    logic                   wr_en_d;
    logic [TDATA_WIDTH:0]   wr_word_d;

    logic rise, room_hdr, room_dat, beat_try;

    // Free space is the pre-edge value, so a same-edge pop never counts.
    assign room_hdr = (free >= FW'(HDR_ROOM));
    assign room_dat = (free >= FW'(DAT_ROOM));
    // trig_q resets high: a trigger still high after reset is mid-frame,
    // not a fresh rising edge.
    assign rise     = TRIGGERED && !trig_q;
    // Falling trigger flushes the delayed beat even without VALID.
    assign beat_try = (state_q == ST_BODY) && (!TRIGGERED || VALID);

    // Decode the FIFO write for this cycle from state and inputs.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_word_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise && room_hdr) begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {1'b0, make_header(CH_ID, BASELINE_WHEN_HIT, TIME_STAMP)};
                end
            end
            ST_BODY: begin
                if (beat_try && room_dat) begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {1'b0, dly_q};
                end
            end
            ST_FOOTER: begin
                wr_en_d   = 1'b1;
                wr_word_d = {1'b1, make_footer(CH_ID, beats_q, trunc_q)};
            end
            default: ;
        endcase
    end

    // Write-side FSM with beat/truncation bookkeeping and drop counters.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= ST_IDLE;
            trig_q      <= 1'b1;
            dly_q       <= '0;
            beats_q     <= '0;
            trunc_q     <= 1'b0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            trig_q <= TRIGGERED;
            unique case (state_q)
                ST_IDLE: begin
                    if (TRIGGERED) begin
                        if (rise && room_hdr) begin
                            state_q <= ST_BODY;
                            dly_q   <= DATA;
                            beats_q <= '0;
                            trunc_q <= 1'b0;
                        end else begin
                            if (rise) drop_cnt_q <= sat_inc16(drop_cnt_q);
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                ST_BODY: begin
                    if (beat_try) begin
                        if (room_dat) beats_q <= sat_inc16(beats_q);
                        else          trunc_q <= 1'b1;
                    end
                    if (TRIGGERED && VALID) dly_q <= DATA;
                    if (!TRIGGERED) state_q <= ST_FOOTER;
                end
                ST_FOOTER: begin
                    if (trunc_q) trunc_cnt_q <= sat_inc16(trunc_cnt_q);
                    if (TRIGGERED) begin
                        drop_cnt_q <= sat_inc16(drop_cnt_q);
                        state_q    <= ST_DISCARD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (!TRIGGERED) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mm_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TDATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (AXIS_ACLK),
        .rst_ni  (AXIS_ARESETN),
        .push_i  (wr_en_d),
        .din_i   (wr_word_d),
        .pop_i   (M_AXIS_TREADY),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .free_o  (free)
    );

    assign M_AXIS_TVALID = !fifo_empty;
    assign M_AXIS_TDATA  = fifo_dout[TDATA_WIDTH-1:0];
    assign M_AXIS_TLAST  = fifo_dout[TDATA_WIDTH];
    assign DROP_COUNT    = drop_cnt_q;
    assign TRUNC_COUNT   = trunc_cnt_q;

endmodule

// File: tb/tb_mm_frame_builder.sv
// Bench for mm_frame_builder: directed table, hand sequences for the
// multi-cycle corners, and a random run against a frame-level model.
module tb_mm_frame_builder;

    localparam int DEPTH = 8;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         trig = 1'b0, valid = 1'b0, tready = 1'b0;
    logic [127:0] data = '0;
    logic [43:0]  ts = '0;
    logic [11:0]  bl = '0;
    logic [127:0] tdata;
    logic         tvalid, tlast;
    logic [15:0]  drop_cnt, trunc_cnt;

    mm_frame_builder #(
        .CH_ID(8'h3C), .FIFO_DEPTH(DEPTH), .TIME_STAMP_WIDTH(44),
        .ADC_RESOLUTION_WIDTH(12), .TDATA_WIDTH(128)
    ) dut (
        .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .TRIGGERED(trig),
        .DATA(data), .VALID(valid), .TIME_STAMP(ts), .BASELINE_WHEN_HIT(bl),
        .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready), .DROP_COUNT(drop_cnt), .TRUNC_COUNT(trunc_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [128:0] hdr_w(input logic [43:0] t, input logic [11:0] b);
        return {1'b0, 8'hAA, 8'h3C, b, 12'h000, t, 44'h0};
    endfunction

    function automatic logic [128:0] ftr_w(input int n, input bit tr);
        logic [15:0] c;
        c = (n > 65535) ? 16'hFFFF : 16'(n);
        return {1'b1, 8'h55, 8'h3C, c, tr, 95'h0};
    endfunction

    // ---------------- frame-level reference model ----------------
    // exp_q mirrors the FIFO contents: what the stream must deliver next.
    logic [128:0] exp_q[$];
    bit           m_prev = 1'b1, m_frame = 1'b0, m_ftr = 1'b0, m_disc = 1'b0, m_trunc = 1'b0;
    logic [127:0] m_pend = '0;
    int           m_beats = 0, m_drop = 0, m_tcnt = 0;
    int           pops = 0;
    logic [128:0] last_pop = '0;
    bit           hold_v = 1'b0;
    logic [128:0] hold_w = '0;

    task automatic model_reset();
        exp_q.delete();
        m_prev = 1'b1; m_frame = 1'b0; m_ftr = 1'b0; m_disc = 1'b0; m_trunc = 1'b0;
        m_pend = '0; m_beats = 0; m_drop = 0; m_tcnt = 0; hold_v = 1'b0;
    endtask

    // One clock edge of the frame rules, using the inputs about to be sampled.
    task automatic model_step();
        int free;
        free = DEPTH - exp_q.size();
        if (exp_q.size() > 0 && tready) void'(exp_q.pop_front());
        if (m_ftr) begin
            exp_q.push_back(ftr_w(m_beats, m_trunc));
            if (m_trunc && m_tcnt < 65535) m_tcnt++;
            m_ftr = 1'b0;
            if (trig) begin
                if (m_drop < 65535) m_drop++;
                m_disc = 1'b1;
            end
        end else if (m_disc) begin
            if (!trig) m_disc = 1'b0;
        end else if (m_frame) begin
            if (!trig || valid) begin
                if (free >= 2) begin exp_q.push_back({1'b0, m_pend}); m_beats++; end
                else m_trunc = 1'b1;
            end
            if (trig && valid) m_pend = data;
            if (!trig) begin m_frame = 1'b0; m_ftr = 1'b1; end
        end else if (trig && !m_prev) begin
            if (free >= 3) begin
                exp_q.push_back(hdr_w(ts, bl));
                m_frame = 1'b1; m_pend = data; m_beats = 0; m_trunc = 1'b0;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_disc = 1'b1;
            end
        end else if (trig) begin
            m_disc = 1'b1;
        end
        m_prev = trig;
    endtask

    // Inputs change 1 time unit after posedge, so the negedge sees exactly
    // what the next posedge will sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tvalid", {128'h0, tvalid}, 129'h0);
            chk("rst_tdata", {tlast, tdata}, 129'h0);
            model_reset();
        end else begin
            chk("tvalid", {128'h0, tvalid}, {128'h0, exp_q.size() > 0});
            chk("drop_count", {113'h0, drop_cnt}, 129'(m_drop));
            chk("trunc_count", {113'h0, trunc_cnt}, 129'(m_tcnt));
            if (hold_v && tvalid) chk("stall_stable", {tlast, tdata}, hold_w);
            hold_v = tvalid && !tready;
            hold_w = {tlast, tdata};
            if (exp_q.size() > 0) chk("head_word", {tlast, tdata}, exp_q[0]);
            if (tvalid && tready) begin pops++; last_pop = {tlast, tdata}; end
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; trig = 1'b0; valid = 1'b0; tready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        trig = 1'b0; tready = 1'b1;
        step(); step();
        while (tvalid && n < lim) begin step(); n++; end
        chk("drain_empty", {128'h0, tvalid}, 129'h0);
    endtask

    typedef struct {
        logic         trig;
        logic         valid;
        logic [127:0] data;
        logic         exp_v;
        logic [128:0] exp_w;
    } vec_t;

    vec_t tv[7];

    initial begin
        int p0, rdy_pct;

        // 4-beat frame, always-ready sink; outputs checked after each edge
        tv[0] = '{1'b1, 1'b1, 128'd1, 1'b1, hdr_w(44'h123, 12'h010)};
        tv[1] = '{1'b1, 1'b1, 128'd2, 1'b1, {1'b0, 128'd1}};
        tv[2] = '{1'b1, 1'b1, 128'd3, 1'b1, {1'b0, 128'd2}};
        tv[3] = '{1'b1, 1'b1, 128'd4, 1'b1, {1'b0, 128'd3}};
        tv[4] = '{1'b0, 1'b1, 128'd0, 1'b1, {1'b0, 128'd4}};
        tv[5] = '{1'b0, 1'b0, 128'd0, 1'b1, ftr_w(4, 1'b0)};
        tv[6] = '{1'b0, 1'b0, 128'd0, 1'b0, 129'h0};

        rst_n = 1'b0;
        step(); step();
        chk("reset_tvalid", {128'h0, tvalid}, 129'h0);
        chk("reset_tdata", {tlast, tdata}, 129'h0);
        chk("reset_drop", {113'h0, drop_cnt}, 129'h0);
        chk("reset_trunc", {113'h0, trunc_cnt}, 129'h0);
        rst_n = 1'b1;
        step(); step();

        ts = 44'h123; bl = 12'h010; tready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            trig = tv[i].trig; valid = tv[i].valid; data = tv[i].data;
            step();
            chk($sformatf("vec%0d_tvalid", i), {128'h0, tvalid}, {128'h0, tv[i].exp_v});
            if (tv[i].exp_v) chk($sformatf("vec%0d_word", i), {tlast, tdata}, tv[i].exp_w);
        end

        // Stalled sink, long trigger: body truncated, footer still lands
        do_reset();
        tready = 1'b0; valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin trig = 1'b1; data = 128'(k); step(); end
        trig = 1'b0; step(); step(); step();
        chk("trunc_count_long", {113'h0, trunc_cnt}, 129'd1);
        chk("head_is_header", {tlast, tdata}, hdr_w(44'h123, 12'h010));
        p0 = pops;
        drain(50);
        chk("words_long", 129'(pops - p0), 129'd8);
        chk("footer_long", last_pop, ftr_w(6, 1'b1));

        // FIFO at 6/8: next rising trigger dropped whole
        do_reset();
        tready = 1'b0; valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin trig = 1'b1; data = 128'(k); step(); end
        trig = 1'b0; step(); step();
        trig = 1'b1; step(); step();
        trig = 1'b0; step(); step();
        chk("drop_full", {113'h0, drop_cnt}, 129'd1);
        p0 = pops;
        drain(50);
        chk("words_full", 129'(pops - p0), 129'd6);
        chk("footer_full", last_pop, ftr_w(4, 1'b0));

        // Trigger re-rises one cycle after falling: footer kept, new frame dropped
        do_reset();
        p0 = pops;
        tready = 1'b1; valid = 1'b1;
        trig = 1'b1; repeat (3) step();
        trig = 1'b0; step();
        trig = 1'b1; repeat (3) step();
        drain(50);
        chk("drop_rerise", {113'h0, drop_cnt}, 129'd1);
        chk("words_rerise", 129'(pops - p0), 129'd5);
        chk("footer_rerise", last_pop, ftr_w(3, 1'b0));

        // Sink toggles ready every cycle during a 3-beat frame
        do_reset();
        p0 = pops;
        valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            trig = (i < 3); tready = i[0]; data = 128'(100 + i);
            step();
        end
        drain(50);
        chk("words_toggle", 129'(pops - p0), 129'd5);
        chk("footer_toggle", last_pop, ftr_w(3, 1'b0));

        // Reset mid-body, released with trigger still high
        do_reset();
        tready = 1'b0; valid = 1'b1; trig = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", {128'h0, tvalid}, 129'h0);
        chk("midrst_tdata", {tlast, tdata}, 129'h0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("postrst_quiet%0d", i), {128'h0, tvalid}, 129'h0);
        end
        trig = 1'b0; step();
        ts = 44'hABCDE; bl = 12'h7F3; trig = 1'b1; tready = 1'b1;
        step();
        chk("postrst_header", {tlast, tdata}, hdr_w(44'hABCDE, 12'h7F3));
        drain(50);

        // Random traffic against the model
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
            if (trig) trig = ($urandom % 10) != 0;
            else      trig = ($urandom % 6) == 0;
            if (!trig) begin ts = {12'($urandom), $urandom}; bl = 12'($urandom); end
            valid  = ($urandom % 4) != 0;
            data   = {$urandom, $urandom, $urandom, $urandom};
            tready = ($urandom % 100) < rdy_pct;
            step();
        end
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
